// File: rtl/ame_pkg.sv
//------------------------------------------------------------------------------
// Module : ame_pkg
// Brief  : Shared types and the round-robin pick function for the AME
//          normalizer arbiter.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package ame_pkg;

    localparam int c_MAX_REQ = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } ame_arb_state_t;

    // One-hot grant of the first set request at or after ptr, wrapping at num_req.
    function automatic logic [c_MAX_REQ-1:0] rr_pick(
        input logic [c_MAX_REQ-1:0] req,
        input logic [2:0]           ptr,
        input int unsigned          num_req
    );
        logic [c_MAX_REQ-1:0] v_grant;
        logic                 v_found;
        int unsigned          v_idx;
        v_grant = '0;
        v_found = 1'b0;
        for (int unsigned k = 0; k < c_MAX_REQ; k++) begin
            v_idx = 32'(ptr) + k;
            if (v_idx >= num_req) begin
                v_idx = v_idx - num_req;
            end
            if ((k < num_req) && !v_found && req[v_idx[2:0]]) begin
                v_grant[v_idx[2:0]] = 1'b1;
                v_found             = 1'b1;
            end
        end
        return v_grant;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ame_norm_arbiter_if.sv
//------------------------------------------------------------------------------
// Module : ame_norm_arbiter_if
// Brief  : Requester bus plus normalizer handshake of the AME normalizer arbiter.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface ame_norm_arbiter_if #(
    parameter int NUM_REQ        = 4,
    parameter int COMP_DATA_BITS = 64
);
    localparam int c_SW = $clog2(COMP_DATA_BITS);

    logic [NUM_REQ-1:0]                req_i;
    logic [NUM_REQ*c_SW-1:0]           shift_i;
    logic [NUM_REQ*COMP_DATA_BITS-1:0] data_i;
    logic [NUM_REQ-1:0]                ack_o;
    logic [NUM_REQ-1:0]                done_o;
    logic                              err_o;
    logic [COMP_DATA_BITS-1:0]         data_o;
    logic                              busy_o;
    logic                              norm_init_o;
    logic [c_SW-1:0]                   norm_shift_o;
    logic [COMP_DATA_BITS-1:0]         norm_data_o;
    logic                              norm_done_i;
    logic [COMP_DATA_BITS-1:0]         norm_data_i;

    modport slave (
        input  req_i, shift_i, data_i, norm_done_i, norm_data_i,
        output ack_o, done_o, err_o, data_o, busy_o,
               norm_init_o, norm_shift_o, norm_data_o
    );

    modport master (
        output req_i, shift_i, data_i, norm_done_i, norm_data_i,
        input  ack_o, done_o, err_o, data_o, busy_o,
               norm_init_o, norm_shift_o, norm_data_o
    );

endinterface

`default_nettype wire

// File: rtl/ame_rr_arbiter.sv
//------------------------------------------------------------------------------
// Module : ame_rr_arbiter
// Brief  : Combinational round-robin pick; pointer register lives in the parent.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module ame_rr_arbiter
    import ame_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  wire logic [NUM_REQ-1:0]         i_req,
    input  wire logic [$clog2(NUM_REQ)-1:0] i_ptr,
    output logic      [NUM_REQ-1:0]         o_grant,
    output logic      [$clog2(NUM_REQ)-1:0] o_grant_idx,
    output logic                            o_valid
);
    localparam int c_IW = $clog2(NUM_REQ);

    logic [c_MAX_REQ-1:0] w_req_ext;
    logic [c_MAX_REQ-1:0] w_pick;

    always_comb begin
        w_req_ext                = '0;
        w_req_ext[NUM_REQ-1:0]   = i_req;
        w_pick                   = rr_pick(w_req_ext, 3'(i_ptr), NUM_REQ);
    end

    assign o_grant = w_pick[NUM_REQ-1:0];
    assign o_valid = |w_pick;

    always_comb begin
        o_grant_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (w_pick[k]) begin
                o_grant_idx = c_IW'(k);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/ame_norm_arbiter.sv
//------------------------------------------------------------------------------
// Module : ame_norm_arbiter
// Brief  : Shares one normalizer between NUM_REQ requesters with round-robin
//          grant, operand capture, init/done sequencing and a watchdog.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module ame_norm_arbiter
    import ame_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int COMP_DATA_BITS = 64,
    parameter int TIMEOUT        = 255
) (
    input  wire logic         clk_i,
    input  wire logic         rst_i,
    ame_norm_arbiter_if.slave bus
);
    localparam int c_SW = $clog2(COMP_DATA_BITS);
    localparam int c_IW = $clog2(NUM_REQ);
    localparam int c_WW = $clog2(TIMEOUT + 1);

    ame_arb_state_t            r_state;
    ame_arb_state_t            w_next_state;
    logic [c_IW-1:0]           r_rr_ptr;
    logic [c_IW-1:0]           r_grant_idx;
    logic [c_WW-1:0]           r_wdog;
    logic                      r_err;
    logic [COMP_DATA_BITS-1:0] r_result;
    logic [c_SW-1:0]           r_shift;
    logic [COMP_DATA_BITS-1:0] r_data;

    logic [NUM_REQ-1:0]        w_grant;
    logic [c_IW-1:0]           w_grant_idx;
    logic                      w_valid;
    logic [c_SW-1:0]           w_sel_shift;
    logic [COMP_DATA_BITS-1:0] w_sel_data;
    logic                      w_timeout;
    logic [c_IW-1:0]           w_next_ptr;
    logic [NUM_REQ-1:0]        w_ack;
    logic [NUM_REQ-1:0]        w_done;
    logic                      w_err;
    logic                      w_busy;
    logic                      w_init;

    ame_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .i_req       (bus.req_i),
        .i_ptr       (r_rr_ptr),
        .o_grant     (w_grant),
        .o_grant_idx (w_grant_idx),
        .o_valid     (w_valid)
    );

    always_comb begin
        w_sel_shift = '0;
        w_sel_data  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (w_grant[k]) begin
                w_sel_shift = bus.shift_i[k*c_SW +: c_SW];
                w_sel_data  = bus.data_i[k*COMP_DATA_BITS +: COMP_DATA_BITS];
            end
        end
    end

    assign w_timeout  = (r_wdog == c_WW'(TIMEOUT));
    assign w_next_ptr = (r_grant_idx == c_IW'(NUM_REQ - 1)) ? '0 : r_grant_idx + c_IW'(1);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = IDLE;
        case (r_state)
            IDLE:    w_next_state = w_valid ? BUSY : IDLE;
            BUSY:    w_next_state = (bus.norm_done_i || w_timeout) ? RESP : BUSY;
            RESP:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rr_ptr    <= '0;
            r_grant_idx <= '0;
            r_wdog      <= '0;
            r_err       <= 1'b0;
            r_result    <= '0;
            r_shift     <= '0;
            r_data      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_valid) begin
                        r_grant_idx <= w_grant_idx;
                        r_shift     <= w_sel_shift;
                        r_data      <= w_sel_data;
                        r_wdog      <= '0;
                    end
                end
                BUSY: begin
                    r_wdog <= r_wdog + c_WW'(1);
                    // A completion in the same cycle as the timeout takes priority.
                    if (bus.norm_done_i) begin
                        r_result <= bus.norm_data_i;
                        r_err    <= 1'b0;
                    end else if (w_timeout) begin
                        r_result <= '0;
                        r_err    <= 1'b1;
                    end
                end
                RESP: begin
                    r_rr_ptr <= w_next_ptr;
                end
                default: begin
                end
            endcase
        end
    end

    // Ack is gated by reset so a request held during reset is never acknowledged.
    always_comb begin
        w_ack  = '0;
        w_done = '0;
        w_err  = 1'b0;
        w_busy = 1'b0;
        w_init = 1'b0;
        case (r_state)
            IDLE: begin
                if (!rst_i) begin
                    w_ack = w_grant;
                end
            end
            BUSY: begin
                w_busy = 1'b1;
                w_init = 1'b1;
            end
            RESP: begin
                w_busy              = 1'b1;
                w_done[r_grant_idx] = 1'b1;
                w_err               = r_err;
            end
            default: begin
            end
        endcase
    end

    assign bus.ack_o        = w_ack;
    assign bus.done_o       = w_done;
    assign bus.err_o        = w_err;
    assign bus.busy_o       = w_busy;
    assign bus.norm_init_o  = w_init;
    assign bus.norm_shift_o = r_shift;
    assign bus.norm_data_o  = r_data;
    assign bus.data_o       = r_result;

endmodule

`default_nettype wire

// File: tb/tb_ame_norm_arbiter.sv
//------------------------------------------------------------------------------
// Module : tb_ame_norm_arbiter
// Brief  : Directed self-checking bench with a 4-cycle arithmetic-shift unit model.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_ame_norm_arbiter;
    localparam int c_L = 4;

    logic        clk;
    logic        rst;
    logic        hang;
    logic        spur;
    logic        m_done;
    logic [63:0] m_data;
    int          m_cnt;
    int          cyc_ctr = 0;
    int          tests   = 0;
    int          fails   = 0;

    ame_norm_arbiter_if #(.NUM_REQ(4), .COMP_DATA_BITS(64)) bus ();

    ame_norm_arbiter #(
        .NUM_REQ        (4),
        .COMP_DATA_BITS (64),
        .TIMEOUT        (15)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc_ctr <= cyc_ctr + 1;

    // Unit model: done rises c_L cycles after init, result = data >>> shift.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cnt  <= 0;
            m_done <= 1'b0;
            m_data <= '0;
        end else if (!bus.norm_init_o) begin
            m_cnt  <= 0;
            m_done <= 1'b0;
        end else if (!hang) begin
            if (m_cnt + 1 >= c_L) begin
                m_done <= 1'b1;
                m_data <= $signed(bus.norm_data_o) >>> bus.norm_shift_o;
            end
            m_cnt <= m_cnt + 1;
        end
    end

    assign bus.norm_done_i = m_done | spur;
    assign bus.norm_data_i = m_data;

    initial begin
        #100000;
        $display("FAIL global_timeout observed=hung expected=finish");
        $fatal(1, "simulation time limit");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_lane(input int k, input logic [63:0] d, input logic [5:0] s);
        bus.data_i[k*64 +: 64] = d;
        bus.shift_i[k*6 +: 6]  = s;
    endtask

    task automatic wait_ack();
        int n;
        n = 0;
        #1;
        while (bus.ack_o == '0 && n < 50) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (bus.done_o == '0 && n < 100) begin
            tick();
            n++;
        end
    endtask

    task automatic run_op(input string tag, input int lane, input logic [63:0] exp_res,
                          input bit drop, output int t_ack);
        wait_ack();
        t_ack = cyc_ctr;
        check({tag, "_ack"}, 64'(bus.ack_o), 64'(1) << lane);
        tick();
        if (drop) bus.req_i = '0;
        check({tag, "_init"}, 64'(bus.norm_init_o), 64'd1);
        wait_done();
        check({tag, "_done"}, 64'(bus.done_o), 64'(1) << lane);
        check({tag, "_err"}, 64'(bus.err_o), 64'd0);
        check({tag, "_data"}, bus.data_o, exp_res);
        check({tag, "_init_resp"}, 64'(bus.norm_init_o), 64'd0);
    endtask

    initial begin
        int t0;
        int t1;
        int cyc;
        int order2[5];
        int order3[3];
        order2 = '{0, 1, 2, 3, 0};
        order3 = '{1, 3, 1};
        rst         = 1'b1;
        hang        = 1'b0;
        spur        = 1'b0;
        bus.req_i   = '0;
        bus.shift_i = '0;
        bus.data_i  = '0;
        tick();
        tick();

        // Reset state, with requests already present
        bus.req_i = 4'b1111;
        #1;
        check("rst_ack", 64'(bus.ack_o), 64'd0);
        check("rst_busy", 64'(bus.busy_o), 64'd0);
        check("rst_init", 64'(bus.norm_init_o), 64'd0);
        check("rst_done", 64'(bus.done_o), 64'd0);
        check("rst_data_o", bus.data_o, 64'd0);
        check("rst_norm_data", bus.norm_data_o, 64'd0);
        check("rst_norm_shift", 64'(bus.norm_shift_o), 64'd0);
        bus.req_i = '0;
        tick();
        rst = 1'b0;
        tick();

        // Single request: lane 2, -256 >>> 4
        set_lane(2, 64'hFFFF_FFFF_FFFF_FF00, 6'd4);
        bus.req_i = 4'b0100;
        #1;
        check("t1_ack_c0", 64'(bus.ack_o), 64'h4);
        tick();
        bus.req_i = '0;
        check("t1_init_c1", 64'(bus.norm_init_o), 64'd1);
        check("t1_busy_c1", 64'(bus.busy_o), 64'd1);
        check("t1_ack_c1", 64'(bus.ack_o), 64'd0);
        check("t1_opnd_data", bus.norm_data_o, 64'hFFFF_FFFF_FFFF_FF00);
        check("t1_opnd_shift", 64'(bus.norm_shift_o), 64'd4);
        tick(); tick(); tick(); tick();
        check("t1_init_c5", 64'(bus.norm_init_o), 64'd1);
        check("t1_done_c5", 64'(bus.done_o), 64'd0);
        tick();
        check("t1_done_c6", 64'(bus.done_o), 64'h4);
        check("t1_err_c6", 64'(bus.err_o), 64'd0);
        check("t1_data_c6", bus.data_o, 64'hFFFF_FFFF_FFFF_FFF0);
        check("t1_init_c6", 64'(bus.norm_init_o), 64'd0);
        tick();
        check("t1_done_c7", 64'(bus.done_o), 64'd0);
        check("t1_busy_c7", 64'(bus.busy_o), 64'd0);
        check("t1_hold_c7", bus.data_o, 64'hFFFF_FFFF_FFFF_FFF0);

        // All lanes requesting from rr_ptr=0
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        for (int k = 0; k < 4; k++) set_lane(k, 64'(1000 * (k + 1)), 6'd1);
        bus.req_i = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            run_op($sformatf("t2_op%0d", i), order2[i], 64'(500 * (order2[i] + 1)), 1'b0, t0);
        end

        // Lane 1 keeps requesting while lane 3 waits
        bus.req_i = 4'b1010;
        for (int i = 0; i < 3; i++) begin
            run_op($sformatf("t3_op%0d", i), order3[i], 64'(500 * (order3[i] + 1)), i == 2, t0);
        end

        // Watchdog abort, then a normal op
        hang      = 1'b1;
        bus.req_i = 4'b0001;
        wait_ack();
        check("t4_ack", 64'(bus.ack_o), 64'h1);
        tick();
        cyc       = 1;
        bus.req_i = '0;
        while (bus.done_o == '0 && cyc < 40) begin
            tick();
            cyc++;
        end
        check("t4_cycle", 64'(cyc), 64'd17);
        check("t4_done", 64'(bus.done_o), 64'h1);
        check("t4_err", 64'(bus.err_o), 64'd1);
        check("t4_data", bus.data_o, 64'd0);
        hang      = 1'b0;
        bus.req_i = 4'b0010;
        run_op("t4_next", 1, 64'd1000, 1'b1, t0);

        // Reset mid-BUSY
        bus.req_i = 4'b0100;
        wait_ack();
        check("t5_ack", 64'(bus.ack_o), 64'h4);
        tick();
        bus.req_i = '0;
        tick();
        rst = 1'b1;
        #1;
        check("t5_init_async", 64'(bus.norm_init_o), 64'd0);
        check("t5_busy_async", 64'(bus.busy_o), 64'd0);
        tick();
        check("t5_done_rst", 64'(bus.done_o), 64'd0);
        check("t5_data_rst", bus.data_o, 64'd0);
        rst = 1'b0;
        tick();
        check("t5_done_after", 64'(bus.done_o), 64'd0);
        bus.req_i = 4'b1111;
        run_op("t5_clean", 0, 64'd500, 1'b1, t0);

        // Back-to-back ops, then a spurious done in IDLE
        bus.req_i = 4'b0011;
        run_op("t6_op0", 1, 64'd1000, 1'b0, t0);
        run_op("t6_op1", 0, 64'd500, 1'b1, t1);
        check("t6_period", 64'(t1 - t0), 64'(c_L + 3));
        tick();
        spur = 1'b1;
        tick();
        spur = 1'b0;
        check("t6_spur_busy", 64'(bus.busy_o), 64'd0);
        check("t6_spur_done", 64'(bus.done_o), 64'd0);
        tick();
        check("t6_spur_done2", 64'(bus.done_o), 64'd0);
        check("t6_spur_data", bus.data_o, 64'd500);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
